// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data) in front of one single-port memory.
// Data side wins ties from idle; completions hand the bus straight to a waiting peer.
module mem_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,

  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_rmask,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,

  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_rmask,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic        bus_err,
  output logic [1:0]  state_dbg
);

  // Handshake: a beat completes in the cycle where valid && ready are both high;
  // a requester keeps valid and payload stable until that cycle.

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);

  // state_dbg encoding: 0 idle, 1 instruction grant, 2 data grant
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] wait_cnt;
  logic          abort;

  assign state_dbg = state;

  always_comb begin
    state_next = state;
    abort      = 1'b0;
    mem_valid  = 1'b0;
    mem_addr   = 32'h0;
    mem_wmask  = 4'h0;
    mem_wdata  = 32'h0;
    mem_rmask  = 4'h0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    imem_rdata = mem_rdata;
    dmem_rdata = mem_rdata;

    case (state)
      IDLE: begin
        if (dmem_valid) begin
          state_next = GNT_D;
        end else if (imem_valid) begin
          state_next = GNT_I;
        end
      end

      GNT_D: begin
        abort      = dmem_valid && !mem_ready && (wait_cnt == WAIT_MAX);
        mem_valid  = dmem_valid && !abort;
        mem_addr   = dmem_addr;
        mem_wmask  = dmem_wmask;
        mem_wdata  = dmem_wdata;
        mem_rmask  = dmem_rmask;
        dmem_ready = mem_ready || abort;
        if (abort) begin
          dmem_rdata = 32'h0;
        end
        // A dropped valid abandons the grant; own valid is ignored on completion.
        if (!dmem_valid) begin
          state_next = IDLE;
        end else if (mem_ready || abort) begin
          state_next = imem_valid ? GNT_I : IDLE;
        end
      end

      GNT_I: begin
        abort      = imem_valid && !mem_ready && (wait_cnt == WAIT_MAX);
        mem_valid  = imem_valid && !abort;
        mem_addr   = imem_addr;
        mem_rmask  = 4'hF;
        imem_ready = mem_ready || abort;
        if (abort) begin
          imem_rdata = 32'h0;
        end
        if (!imem_valid) begin
          state_next = IDLE;
        end else if (mem_ready || abort) begin
          state_next = dmem_valid ? GNT_D : IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state <= state_next;
      // Every grant change (including I<->D hand-over) starts a fresh wait window.
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (state != IDLE && !mem_ready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      bus_err <= bus_err | abort;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter against a bus-ownership reference model.
module tb_mem_arbiter;

  localparam int TO = 8;
  localparam int NONE = 0;
  localparam int INST = 1;
  localparam int DATA = 2;
  localparam logic [1:0] IDLE_DBG = 2'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_rmask;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_rmask;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bus, and how many stalled cycles it has waited
  int m_owner = NONE;
  int m_stall = 0;
  bit m_berr  = 1'b0;
  bit m_known = 1'b0;
  int n_owner = NONE;
  int n_stall = 0;
  bit n_berr  = 1'b0;
  bit last_i_hs = 1'b0;
  bit last_d_hs = 1'b0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_valid (dmem_valid),
    .dmem_addr  (dmem_addr),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rmask (dmem_rmask),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rmask  (mem_rmask),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .bus_err    (bus_err),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model at the negedge, then work out the model's next owner.
  task automatic eval();
    bit          g_valid;
    bit          o_valid;
    bit          ab;
    bit          e_mv;
    logic [31:0] e_ma;
    logic [3:0]  e_wm;
    logic [31:0] e_wd;
    logic [3:0]  e_rm;
    bit          e_ir;
    bit          e_dr;
    logic [31:0] e_ird;
    logic [31:0] e_drd;
    @(negedge clk);
    g_valid = 1'b0;
    o_valid = 1'b0;
    ab      = 1'b0;
    e_mv    = 1'b0;
    e_ma    = 32'h0;
    e_wm    = 4'h0;
    e_wd    = 32'h0;
    e_rm    = 4'h0;
    e_ir    = 1'b0;
    e_dr    = 1'b0;
    e_ird   = mem_rdata;
    e_drd   = mem_rdata;
    if (m_known) begin
      if (m_owner == DATA) begin
        g_valid = dmem_valid;
        o_valid = imem_valid;
        ab      = g_valid && !mem_ready && (m_stall == TO - 1);
        e_mv    = g_valid && !ab;
        e_ma    = dmem_addr;
        e_wm    = dmem_wmask;
        e_wd    = dmem_wdata;
        e_rm    = dmem_rmask;
        e_dr    = mem_ready || ab;
        if (ab) e_drd = 32'h0;
      end else if (m_owner == INST) begin
        g_valid = imem_valid;
        o_valid = dmem_valid;
        ab      = g_valid && !mem_ready && (m_stall == TO - 1);
        e_mv    = g_valid && !ab;
        e_ma    = imem_addr;
        e_rm    = 4'hF;
        e_ir    = mem_ready || ab;
        if (ab) e_ird = 32'h0;
      end
      chk("mem_valid", mem_valid, e_mv);
      chk("mem_addr", mem_addr, e_ma);
      chk("mem_wmask", mem_wmask, e_wm);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("mem_rmask", mem_rmask, e_rm);
      chk("imem_ready", imem_ready, e_ir);
      chk("dmem_ready", dmem_ready, e_dr);
      chk("imem_rdata", imem_rdata, e_ird);
      chk("dmem_rdata", dmem_rdata, e_drd);
      chk("bus_err", bus_err, m_berr);
      chk("one_ready", imem_ready && dmem_ready, 1'b0);

      if (m_owner == NONE) begin
        n_owner = dmem_valid ? DATA : (imem_valid ? INST : NONE);
      end else if (!g_valid) begin
        n_owner = NONE;
      end else if (mem_ready || ab) begin
        n_owner = o_valid ? ((m_owner == DATA) ? INST : DATA) : NONE;
      end else begin
        n_owner = m_owner;
      end
      if (n_owner != m_owner) n_stall = 0;
      else if (m_owner != NONE && !mem_ready) n_stall = m_stall + 1;
      else n_stall = m_stall;
      n_berr = m_berr | ab;
    end
    last_i_hs = (imem_valid && imem_ready);
    last_d_hs = (dmem_valid && dmem_ready);
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      m_owner = NONE;
      m_stall = 0;
      m_berr  = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      m_owner = n_owner;
      m_stall = n_stall;
      m_berr  = n_berr;
    end
    #1;
  endtask

  task automatic step();
    eval();
    advance();
  endtask

  task automatic set_d(input bit v, input logic [31:0] a, input logic [3:0] wm,
                       input logic [31:0] wd, input logic [3:0] rm);
    dmem_valid = v;
    dmem_addr  = a;
    dmem_wmask = wm;
    dmem_wdata = wd;
    dmem_rmask = rm;
  endtask

  initial begin
    int stall_left;
    bit wr;
    reset      = 1'b1;
    imem_valid = 1'b0;
    imem_addr  = 32'h0;
    set_d(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
    mem_ready  = 1'b0;
    mem_rdata  = 32'h1234_5678;

    // Reset: outputs other than rdata passthroughs are zero
    advance();
    eval();
    chk("rst_state", state_dbg, IDLE_DBG);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_mem_valid", mem_valid, 1'b0);
    advance();
    reset = 1'b0;
    step();

    // Zero-wait data write from idle
    mem_ready = 1'b1;
    set_d(1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 4'h0);
    eval();
    chk("t1_idle_mv", mem_valid, 1'b0);
    advance();
    eval();
    chk("t1_mv", mem_valid, 1'b1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_wmask", mem_wmask, 4'hF);
    chk("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t1_dready", dmem_ready, 1'b1);
    advance();
    set_d(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
    eval();
    chk("t1_after_state", state_dbg, IDLE_DBG);
    chk("t1_after_mv", mem_valid, 1'b0);
    advance();

    // Both requesters continuously valid: D, I, D, I with no gap
    imem_valid = 1'b1;
    imem_addr  = 32'h0;
    set_d(1'b1, 32'h200, 4'h0, 32'h0, 4'hF);
    step();
    for (int k = 0; k < 4; k++) begin
      eval();
      chk("t2_mv", mem_valid, 1'b1);
      chk("t2_addr", mem_addr, (k % 2 == 0) ? 32'h200 : 32'h0);
      advance();
    end
    imem_valid = 1'b0;
    set_d(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
    step();
    step();

    // Instruction fetch with three wait cycles
    mem_ready  = 1'b0;
    imem_valid = 1'b1;
    imem_addr  = 32'h40;
    step();
    for (int g = 1; g <= 4; g++) begin
      mem_ready = (g == 4);
      mem_rdata = (g == 4) ? 32'h0000_0013 : $urandom;
      eval();
      chk("t3_iready", imem_ready, (g == 4));
      chk("t3_dready", dmem_ready, 1'b0);
      if (g == 4) chk("t3_rdata", imem_rdata, 32'h0000_0013);
      advance();
    end
    imem_valid = 1'b0;
    mem_ready  = 1'b0;
    step();

    // Timeout abort on a data read that never gets ready
    mem_rdata = 32'hA5A5_A5A5;
    set_d(1'b1, 32'h300, 4'h0, 32'h0, 4'hF);
    step();
    for (int g = 1; g <= TO; g++) begin
      eval();
      chk("t4_dready", dmem_ready, (g == TO));
      chk("t4_mv", mem_valid, (g != TO));
      chk("t4_berr_pre", bus_err, 1'b0);
      if (g == TO) chk("t4_rdata", dmem_rdata, 32'h0);
      advance();
    end
    set_d(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      eval();
      chk("t4_berr_sticky", bus_err, 1'b1);
      advance();
    end

    // Reset during the second wait cycle of a data transfer
    set_d(1'b1, 32'h400, 4'h0, 32'h0, 4'hF);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_d(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
    imem_valid = 1'b1;
    imem_addr  = 32'h80;
    mem_ready  = 1'b1;
    eval();
    chk("t5_mv", mem_valid, 1'b0);
    chk("t5_dready", dmem_ready, 1'b0);
    chk("t5_berr", bus_err, 1'b0);
    chk("t5_state", state_dbg, IDLE_DBG);
    advance();
    eval();
    chk("t5_fetch_mv", mem_valid, 1'b1);
    chk("t5_fetch_addr", mem_addr, 32'h80);
    chk("t5_fetch_iready", imem_ready, 1'b1);
    advance();
    imem_valid = 1'b0;
    step();

    // Random traffic: legal requesters with occasional violations, stalls and resets
    stall_left = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (last_i_hs || !imem_valid) begin
        imem_valid = ($urandom_range(0, 2) != 0);
        imem_addr  = 32'($urandom_range(0, 1023)) << 2;
      end else if ($urandom_range(0, 59) == 0) begin
        imem_valid = 1'b0;
      end
      if (last_d_hs || !dmem_valid) begin
        wr = $urandom_range(0, 1) != 0;
        set_d($urandom_range(0, 2) != 0, 32'($urandom_range(0, 1023)) << 2,
              wr ? 4'($urandom_range(1, 15)) : 4'h0, wr ? 32'($urandom) : 32'h0,
              wr ? 4'h0 : 4'($urandom_range(1, 15)));
      end else if ($urandom_range(0, 59) == 0) begin
        dmem_valid = 1'b0;
      end
      if (reset) begin
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
      end
      if (stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
      end else begin
        if ($urandom_range(0, 39) == 0) stall_left = 10;
        mem_ready = ($urandom_range(0, 2) != 0);
      end
      mem_rdata = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, the number of granted cycles without mem_ready before a bus-error abort.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports imem_valid in 1, imem_addr in 32, imem_ready out 1, imem_rdata out 32: instruction-fetch requester, read-only.
REQ-005 SHALL have ports dmem_valid in 1, dmem_addr in 32, dmem_wmask in 4, dmem_wdata in 32, dmem_rmask in 4, dmem_ready out 1, dmem_rdata out 32: data requester.
REQ-006 SHALL have ports mem_valid out 1, mem_addr out 32, mem_wmask out 4, mem_wdata out 32, mem_rmask out 4, mem_ready in 1, mem_rdata in 32: shared single-port memory.
REQ-007 SHALL have port bus_err  output  1  sticky flag, set on any timeout abort.

Function
REQ-008 SHALL implement states IDLE, GNT_I, GNT_D in a registered state machine.
REQ-009 Handshake: a transfer completes in the cycle where valid and ready are both high; a requester holds valid and payload stable until then.
REQ-010 In IDLE: mem_valid, mem_addr, mem_wmask, mem_wdata, mem_rmask SHALL be 0; imem_ready and dmem_ready SHALL be 0.
REQ-011 IDLE transitions: dmem_valid=1 -> GNT_D; else imem_valid=1 -> GNT_I; else stay (dmem has priority when both are valid).
REQ-012 In GNT_D: mem_* SHALL equal dmem_* combinationally (mem_valid=dmem_valid); dmem_ready=mem_ready; imem_ready=0.
REQ-013 In GNT_I: mem_valid=imem_valid, mem_addr=imem_addr, mem_rmask=4'hF, mem_wmask=0, mem_wdata=0; imem_ready=mem_ready; dmem_ready=0.
REQ-014 imem_rdata and dmem_rdata SHALL both equal mem_rdata in every state; they are qualified only by the respective ready.
REQ-015 Latency: a request arriving in IDLE at cycle N SHALL see mem_valid high at N+1; with zero-wait memory, ready at N+1.
REQ-016 On completion in GNT_x: if the other requester's valid is high, next state SHALL be the other grant; otherwise IDLE. The completing requester's own valid SHALL be ignored in that cycle.
REQ-017 Consequence of REQ-016: with both requesters continuously valid, grants SHALL alternate D,I,D,I with no idle cycle between them.
REQ-018 A back-to-back request from the same requester, with the other idle, SHALL incur exactly one IDLE cycle.
REQ-019 If the granted requester drops valid before completion (protocol violation), mem_valid SHALL fall in the same cycle and the state SHALL return to IDLE on the next edge.
REQ-020 A wait counter, clog2(TIMEOUT) bits wide, SHALL clear on entry to GNT_I/GNT_D and increment each granted cycle with mem_ready=0.
REQ-021 When the wait counter equals TIMEOUT-1 and mem_ready=0, the arbiter SHALL abort in that cycle: mem_valid=0, granted ready=1, granted rdata=32'h0. Next state SHALL follow REQ-016, and bus_err SHALL be set on the next edge.
REQ-022 bus_err SHALL remain 1 until reset and SHALL NOT change arbitration behaviour.
REQ-023 The arbiter SHALL never assert imem_ready and dmem_ready in the same cycle, and SHALL never change the mem_* source while mem_valid=1 and mem_ready=0, except on abort.

Reset
REQ-024 At a rising edge with reset=1: state=IDLE, wait counter=0, bus_err=0.
REQ-025 Consequently, after that edge all outputs except the rdata passthroughs SHALL be 0.
REQ-026 Reset asserted mid-transfer SHALL abandon the transfer without asserting any ready after the edge; the transfer is not retried.
REQ-027 After reset deasserts, the first arbitration SHALL occur in the first IDLE cycle per REQ-011.

Verification
REQ-028 Bench SHALL cover: dmem write of addr 0x100, wmask 4'hF, wdata 0xDEADBEEF from IDLE, zero-wait memory -> mem_valid at N+1 with matching payload; dmem_ready=1 at N+1; then IDLE.
REQ-029 Bench SHALL cover: both valid continuously (imem 0x0, dmem 0x200), zero-wait memory -> mem_addr sequence 0x200,0x0,0x200,0x0; no idle cycles after the first.
REQ-030 Bench SHALL cover: imem fetch at 0x40 with memory returning 0x00000013 after 3 wait cycles -> imem_ready high only on the 4th granted cycle; imem_rdata=0x00000013; dmem_ready=0 throughout.
REQ-031 Bench SHALL cover: TIMEOUT=8, mem_ready held 0 on a dmem read -> dmem_ready=1 with dmem_rdata=0 on the 8th granted cycle; bus_err=1 from the next cycle until reset.
REQ-032 Bench SHALL cover: reset asserted during the 2nd wait cycle of a dmem transfer -> after the edge, mem_valid=0, dmem_ready=0, bus_err=0, state IDLE; after reset release, a fresh imem request is served at N+1.
